// File: rtl/planificador_elevador.sv
// Trip scheduler for the five-stop car: SCAN sweep over the latched requests,
// motor sequencing through accion, door timing and request clear pulses.
module planificador_elevador #(
    parameter logic [15:0] T_PUERTA   = 16'd200,
    parameter logic [7:0]  T_ARRANQUE = 8'd4
) (
    input  logic       _clk_,
    input  logic       _reset_n_,
    input  logic [2:0] piso_actual,
    input  logic       en_piso,
    input  logic [9:0] solicitudes,
    output logic [1:0] accion,
    output logic       puerta_abierta,
    output logic [9:0] clear_solicitudes,
    output logic       FSM_ready,
    output logic       error_piso
);

    localparam int unsigned N_PISOS = 5;
    localparam int unsigned W_SOL   = 2 * N_PISOS;

    localparam logic [2:0] REPOSO   = 3'd0;
    localparam logic [2:0] ARRANQUE = 3'd1;
    localparam logic [2:0] MOVIENDO = 3'd2;
    localparam logic [2:0] PUERTA   = 3'd3;
    localparam logic [2:0] FALLA    = 3'd4;

    localparam logic SUBIR = 1'b0;
    localparam logic BAJAR = 1'b1;

    // Floor-0 bajar and floor-4 subir can never pull the car anywhere.
    localparam logic [W_SOL-1:0] SIN_RUMBO = 10'h201;

    logic [2:0]       estado, estado_d;
    logic             dir, dir_d;
    logic [15:0]      cnt_puerta, cnt_puerta_d;
    logic [7:0]       cnt_arranque, cnt_arranque_d;
    logic [2:0]       piso_inicio, piso_inicio_d;
    logic [1:0]       accion_d;
    logic             puerta_d;
    logic [W_SOL-1:0] clear_d;
    logic             ready_d;
    logic             error_d;

    logic [W_SOL-1:0] rumbo;
    logic [W_SOL-1:0] m_sub, m_baj, m_dir, m_otro;
    logic             aqui, arriba, abajo, adelante, detras;
    logic [W_SOL-1:0] pulso_entrada;
    logic             parada;
    logic             entrar;

    assign rumbo = solicitudes & ~SIN_RUMBO;

    // Request position flags relative to the current floor.
    always_comb begin
        aqui   = 1'b0;
        arriba = 1'b0;
        abajo  = 1'b0;
        m_sub  = '0;
        m_baj  = '0;
        for (int unsigned k = 0; k < N_PISOS; k++) begin
            if (3'(k) == piso_actual) begin
                aqui           = solicitudes[2*k+1] | solicitudes[2*k];
                m_sub[2*k+1]   = 1'b1;
                m_baj[2*k]     = 1'b1;
            end else if (3'(k) > piso_actual) begin
                arriba = arriba | rumbo[2*k+1] | rumbo[2*k];
            end else begin
                abajo = abajo | rumbo[2*k+1] | rumbo[2*k];
            end
        end
    end

    // Direction-relative views, stop decision and door-entry clear pattern.
    always_comb begin
        m_dir    = (dir == BAJAR) ? m_baj : m_sub;
        m_otro   = (dir == BAJAR) ? m_sub : m_baj;
        adelante = (dir == BAJAR) ? abajo : arriba;
        detras   = (dir == BAJAR) ? arriba : abajo;
        // The opposite-direction bit is only served on a turnaround.
        if (solicitudes == '0) begin
            pulso_entrada = '0;
        end else begin
            pulso_entrada = m_dir | (adelante ? '0 : (m_otro & solicitudes));
        end
        parada = (|(solicitudes & m_dir))
               | (aqui & ~adelante)
               | ((piso_actual == 3'd4) & (dir == SUBIR))
               | ((piso_actual == 3'd0) & (dir == BAJAR))
               | (solicitudes == '0);
    end

    // Next-state and next-output logic.
    always_comb begin
        estado_d       = estado;
        dir_d          = dir;
        cnt_puerta_d   = cnt_puerta;
        cnt_arranque_d = cnt_arranque;
        piso_inicio_d  = piso_inicio;
        accion_d       = accion;
        puerta_d       = puerta_abierta;
        clear_d        = '0;
        error_d        = error_piso;
        entrar         = 1'b0;

        case (estado)
            REPOSO: begin
                accion_d = 2'b00;
                if (aqui && en_piso) begin
                    entrar = 1'b1;
                end else if (adelante || detras) begin
                    estado_d       = ARRANQUE;
                    dir_d          = adelante ? dir : ~dir;
                    cnt_arranque_d = T_ARRANQUE;
                    piso_inicio_d  = piso_actual;
                end
            end
            ARRANQUE: begin
                accion_d = 2'b00;
                if (cnt_arranque <= 8'd1) begin
                    estado_d       = MOVIENDO;
                    cnt_arranque_d = '0;
                    accion_d       = {1'b1, dir};
                end else begin
                    cnt_arranque_d = cnt_arranque - 8'd1;
                end
            end
            MOVIENDO: begin
                accion_d = {1'b1, dir};
                if (en_piso && (piso_actual != piso_inicio) && parada) begin
                    entrar = 1'b1;
                end
            end
            PUERTA: begin
                accion_d = 2'b00;
                // Skip the bit we pulsed last cycle: the register may not have dropped it yet.
                if ((solicitudes & m_dir & ~clear_solicitudes) != '0) begin
                    cnt_puerta_d = T_PUERTA;
                    clear_d      = m_dir;
                end else if (cnt_puerta <= 16'd1) begin
                    cnt_puerta_d = '0;
                    puerta_d     = 1'b0;
                    estado_d     = REPOSO;
                end else begin
                    cnt_puerta_d = cnt_puerta - 16'd1;
                end
            end
            FALLA: begin
                accion_d = 2'b00;
                puerta_d = 1'b0;
                error_d  = 1'b1;
            end
            default: begin
                estado_d = FALLA;
                accion_d = 2'b00;
                puerta_d = 1'b0;
            end
        endcase

        if (entrar) begin
            estado_d     = PUERTA;
            accion_d     = 2'b00;
            puerta_d     = 1'b1;
            cnt_puerta_d = T_PUERTA;
            clear_d      = pulso_entrada;
            dir_d        = adelante ? dir : ~dir;
        end

        if (piso_actual > 3'd4) begin
            estado_d = FALLA;
            accion_d = 2'b00;
            puerta_d = 1'b0;
            clear_d  = '0;
            error_d  = 1'b1;
        end

        ready_d = (estado_d == REPOSO);
    end

    // State and output registers.
    always_ff @(posedge _clk_ or negedge _reset_n_) begin
        if (!_reset_n_) begin
            estado            <= REPOSO;
            dir               <= SUBIR;
            cnt_puerta        <= '0;
            cnt_arranque      <= '0;
            piso_inicio       <= '0;
            accion            <= 2'b00;
            puerta_abierta    <= 1'b0;
            clear_solicitudes <= '0;
            FSM_ready         <= 1'b1;
            error_piso        <= 1'b0;
        end else begin
            estado            <= estado_d;
            dir               <= dir_d;
            cnt_puerta        <= cnt_puerta_d;
            cnt_arranque      <= cnt_arranque_d;
            piso_inicio       <= piso_inicio_d;
            accion            <= accion_d;
            puerta_abierta    <= puerta_d;
            clear_solicitudes <= clear_d;
            FSM_ready         <= ready_d;
            error_piso        <= error_d;
        end
    end

endmodule

// File: tb/tb_planificador_elevador.sv
// Bench for planificador_elevador: car/request-register model plus a queue of
// expected clear pulses compared against the pulses the DUT emits.
module tb_planificador_elevador;

    logic       clk;
    logic       rst_n;
    logic [2:0] piso;
    logic       en;
    logic [9:0] sol;
    logic [1:0] accion;
    logic       puerta_abierta;
    logic [9:0] clear_solicitudes;
    logic       fsm_ready;
    logic       error_piso;

    int total;
    int bad;
    int overlap;
    int door_cycles;
    int mcnt;
    bit car_auto;

    logic [9:0] exp_q[$];
    logic [9:0] obs_q[$];

    planificador_elevador dut (
        ._clk_             (clk),
        ._reset_n_         (rst_n),
        .piso_actual       (piso),
        .en_piso           (en),
        .solicitudes       (sol),
        .accion            (accion),
        .puerta_abierta    (puerta_abierta),
        .clear_solicitudes (clear_solicitudes),
        .FSM_ready         (fsm_ready),
        .error_piso        (error_piso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: record pulses, update request register and car position.
    task automatic tick();
        @(posedge clk);
        #1;
        if (clear_solicitudes != 10'h000) begin
            obs_q.push_back(clear_solicitudes);
            sol = sol & ~clear_solicitudes;
        end
        if (accion[1] && puerta_abierta) overlap++;
        if (puerta_abierta) door_cycles++;
        if (car_auto) begin
            if (accion[1]) begin
                mcnt++;
                if (mcnt == 5) begin
                    mcnt = 0;
                    if (accion[0]) begin
                        if (piso > 3'd0) piso = piso - 3'd1;
                    end else begin
                        if (piso < 3'd4) piso = piso + 3'd1;
                    end
                end
                en = (mcnt < 2);
            end else begin
                mcnt = 0;
                en   = 1'b1;
            end
        end
    endtask

    task automatic wait_door(input logic lvl, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            tick();
            if (puerta_abierta === lvl) ok = 1'b1;
        end
    endtask

    task automatic wait_motor(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            tick();
            if (accion[1] === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic apply_reset(input logic [2:0] p);
        rst_n    = 1'b0;
        sol      = 10'h000;
        piso     = p;
        en       = 1'b1;
        car_auto = 1'b1;
        mcnt     = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        door_cycles = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        piso = 3'd0; en = 1'b1; sol = 10'h000; car_auto = 1'b1; mcnt = 0;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (accion !== 2'b00) begin bad++; $display("FAIL rst_accion: got %b want 00", accion); end
        total++; if (puerta_abierta !== 1'b0) begin bad++; $display("FAIL rst_puerta: got %b want 0", puerta_abierta); end
        total++; if (clear_solicitudes !== 10'h000) begin bad++; $display("FAIL rst_clear: got %h want 000", clear_solicitudes); end
        total++; if (fsm_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", fsm_ready); end
        total++; if (error_piso !== 1'b0) begin bad++; $display("FAIL rst_error: got %b want 0", error_piso); end
        apply_reset(3'd0);
    endtask

    task automatic test_trip_up();
        bit ok;
        int n;
        logic [9:0] o, e;
        apply_reset(3'd0);
        sol[7] = 1'b1;
        exp_q.push_back(10'h080);
        tick();
        total++; if (fsm_ready !== 1'b0) begin bad++; $display("FAIL t1_ready_arr: got %b want 0", fsm_ready); end
        total++; if (accion !== 2'b00) begin bad++; $display("FAIL t1_accion_arr: got %b want 00", accion); end
        n = 1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            tick();
            n++;
            if (accion[1] === 1'b1) ok = 1'b1;
        end
        total++; if (!ok || n != 5) begin bad++; $display("FAIL t1_arranque_len: got %0d want 5", n); end
        total++; if (accion !== 2'b10) begin bad++; $display("FAIL t1_accion_move: got %b want 10", accion); end
        wait_door(1'b1, ok);
        total++; if (!ok) begin bad++; $display("FAIL t1_door_timeout: got 0 want 1"); end
        total++; if (piso !== 3'd3) begin bad++; $display("FAIL t1_stop_floor: got %0d want 3", piso); end
        total++; if (accion !== 2'b00) begin bad++; $display("FAIL t1_accion_stop: got %b want 00", accion); end
        wait_door(1'b0, ok);
        total++; if (door_cycles != 200) begin bad++; $display("FAIL t1_door_len: got %0d want 200", door_cycles); end
        total++; if (fsm_ready !== 1'b1) begin bad++; $display("FAIL t1_ready_end: got %b want 1", fsm_ready); end
        total++;
        if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL t1_pulse_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL t1_pulse: got %h want %h", o, e); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_turnaround();
        bit ok;
        logic [9:0] o, e;
        apply_reset(3'd0);
        sol = 10'h104;
        exp_q.push_back(10'h300);
        wait_door(1'b1, ok);
        total++; if (!ok || piso !== 3'd4) begin bad++; $display("FAIL t2_first_stop: got %0d want 4", piso); end
        wait_door(1'b0, ok);
        exp_q.push_back(10'h004);
        wait_door(1'b1, ok);
        total++; if (!ok || piso !== 3'd1) begin bad++; $display("FAIL t2_second_stop: got %0d want 1", piso); end
        wait_door(1'b0, ok);
        total++; if (sol !== 10'h000) begin bad++; $display("FAIL t2_sol_left: got %h want 000", sol); end
        total++;
        if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL t2_pulse_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL t2_pulse: got %h want %h", o, e); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_same_floor();
        bit ok;
        logic [9:0] o, e;
        apply_reset(3'd1);
        sol = 10'h008;
        exp_q.push_back(10'h008);
        tick();
        total++; if (puerta_abierta !== 1'b1) begin bad++; $display("FAIL t3_puerta: got %b want 1", puerta_abierta); end
        total++; if (accion !== 2'b00) begin bad++; $display("FAIL t3_accion: got %b want 00", accion); end
        total++; if (fsm_ready !== 1'b0) begin bad++; $display("FAIL t3_ready: got %b want 0", fsm_ready); end
        wait_door(1'b0, ok);
        total++; if (!ok || door_cycles != 200) begin bad++; $display("FAIL t3_door_len: got %0d want 200", door_cycles); end
        total++;
        if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL t3_pulse_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL t3_pulse: got %h want %h", o, e); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_door_reload();
        bit ok;
        logic [9:0] o, e;
        apply_reset(3'd0);
        sol = 10'h0A0;
        exp_q.push_back(10'h020);
        wait_door(1'b1, ok);
        total++; if (!ok || piso !== 3'd2) begin bad++; $display("FAIL t4_stop_floor: got %0d want 2", piso); end
        repeat (190) tick();
        sol[5] = 1'b1;
        exp_q.push_back(10'h020);
        tick();
        total++; if (clear_solicitudes !== 10'h020) begin bad++; $display("FAIL t4_reload_pulse: got %h want 020", clear_solicitudes); end
        wait_door(1'b0, ok);
        total++; if (!ok || door_cycles != 391) begin bad++; $display("FAIL t4_door_len: got %0d want 391", door_cycles); end
        exp_q.push_back(10'h080);
        wait_door(1'b1, ok);
        total++; if (!ok || piso !== 3'd3) begin bad++; $display("FAIL t4_next_stop: got %0d want 3", piso); end
        wait_door(1'b0, ok);
        total++;
        if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL t4_pulse_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL t4_pulse: got %h want %h", o, e); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_fault();
        bit ok;
        apply_reset(3'd0);
        sol = 10'h080;
        wait_motor(ok);
        total++; if (!ok) begin bad++; $display("FAIL t5_motor_timeout: got 0 want 1"); end
        repeat (2) tick();
        car_auto = 1'b0;
        piso = 3'b110;
        tick();
        total++; if (accion !== 2'b00) begin bad++; $display("FAIL t5_accion: got %b want 00", accion); end
        total++; if (error_piso !== 1'b1) begin bad++; $display("FAIL t5_error: got %b want 1", error_piso); end
        total++; if (fsm_ready !== 1'b0) begin bad++; $display("FAIL t5_ready: got %b want 0", fsm_ready); end
        piso = 3'd2;
        en = 1'b1;
        repeat (20) tick();
        total++; if (error_piso !== 1'b1 || accion !== 2'b00) begin bad++; $display("FAIL t5_sticky: got err=%b acc=%b want err=1 acc=00", error_piso, accion); end
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL t5_pulses: got %0d want 0", obs_q.size()); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (error_piso !== 1'b0) begin bad++; $display("FAIL t5_error_clear: got %b want 0", error_piso); end
        obs_q.delete(); exp_q.delete();
        apply_reset(3'd0);
    endtask

    task automatic test_reset_mid_trip();
        bit ok;
        apply_reset(3'd4);
        sol = 10'h004;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            tick();
            if (accion === 2'b11) ok = 1'b1;
        end
        total++; if (!ok) begin bad++; $display("FAIL t6_down_move: got %b want 11", accion); end
        repeat (2) tick();
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (accion !== 2'b00) begin bad++; $display("FAIL t6_async_accion: got %b want 00", accion); end
        total++; if (fsm_ready !== 1'b1 || puerta_abierta !== 1'b0) begin bad++; $display("FAIL t6_async_out: got rdy=%b door=%b want rdy=1 door=0", fsm_ready, puerta_abierta); end
        piso = 3'd2; en = 1'b1; mcnt = 0; sol = 10'h084;
        @(posedge clk);
        #1;
        total++; if (clear_solicitudes !== 10'h000) begin bad++; $display("FAIL t6_no_pulse: got %h want 000", clear_solicitudes); end
        rst_n = 1'b1;
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL t6_pulses: got %0d want 0", obs_q.size()); end
        wait_motor(ok);
        total++; if (!ok || accion !== 2'b10) begin bad++; $display("FAIL t6_dir_after: got %b want 10", accion); end
        obs_q.delete(); exp_q.delete();
        apply_reset(3'd0);
    endtask

    task automatic test_invariants();
        total++; if (overlap != 0) begin bad++; $display("FAIL motor_door_overlap: got %0d want 0", overlap); end
    endtask

    initial begin
        total = 0; bad = 0; overlap = 0; door_cycles = 0; mcnt = 0;
        car_auto = 1'b1;
        rst_n = 1'b0; piso = 3'd0; en = 1'b1; sol = 10'h000;
        repeat (2) @(posedge clk);
        test_reset();
        test_trip_up();
        test_turnaround();
        test_same_floor();
        test_door_reload();
        test_fault();
        test_reset_mid_trip();
        test_invariants();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/planificador_elevador.md
Name: planificador_elevador

Overview:
Trip scheduler for the 5-stop car (sotano, pisos 1-4). It holds the latched hall/cab requests and the current-floor code, and sequences the motor through the `accion` pair (enable, direction). It runs a directional sweep (SCAN): keep the travel direction while requests remain ahead, stop at serviced floors, run the door timer, then pulse clear lines back to the request register. It sits between the request register and the motor/door drivers.

Parameters:
T_PUERTA, 16'd200, clock cycles the door stays open per stop (>=1)
T_ARRANQUE, 8'd4, cycles held in ARRANQUE before motor enable (>=1)

Ports:
_clk_  input  1  system clock, rising edge
_reset_n_  input  1  asynchronous, active-low reset
piso_actual  input  3  current floor, binary 0=sotano .. 4=piso4; 5-7 invalid
en_piso  input  1  car aligned at piso_actual (level)
solicitudes  input  10  bits [2k+1:2k] = floor k; bit 2k+1 = subir request, bit 2k = bajar request
accion  output  2  [1]=motor enable (1=on), [0]=direction (0=subir, 1=bajar)
puerta_abierta  output  1  door open command
clear_solicitudes  output  10  one-cycle pulses, same bit map as solicitudes
FSM_ready  output  1  high only in REPOSO
error_piso  output  1  sticky; set when piso_actual>4 is seen

Behaviour:
- One clock `_clk_`; reset is asynchronous and active-low on `_reset_n_`. All state and outputs are registered.
- Reset values: state=REPOSO, accion=2'b00, puerta_abierta=0, clear_solicitudes=0, FSM_ready=1, error_piso=0, dir=subir, counters=0.
- Derived flags, computed each cycle from `solicitudes` and `piso_actual`:
  - aqui = any bit of floor piso_actual
  - arriba = any bit of floors > piso_actual
  - abajo = any bit of floors < piso_actual
- States: REPOSO, ARRANQUE, MOVIENDO, PUERTA, FALLA.
- REPOSO (accion=00):
  - aqui & en_piso -> PUERTA.
  - else arriba -> dir=subir, go ARRANQUE.
  - else abajo -> dir=bajar, go ARRANQUE.
  - Priority: aqui > arriba > abajo, but while dir=bajar the order is aqui > abajo > arriba.
  - Decision takes effect 1 cycle after the request is visible.
- ARRANQUE: accion=00 for T_ARRANQUE cycles, then MOVIENDO.
- MOVIENDO: accion={1,dir}.
  - A stop is evaluated on every cycle with en_piso=1 and piso_actual different from the floor at which the move started.
  - Stop if any of:
    - the request bit in dir at this floor is set;
    - the floor has any request and there is nothing further ahead in dir;
    - the floor is 4 while going up;
    - the floor is 0 while going down.
  - On stop: accion=00 in the same registered update, go PUERTA.
- PUERTA entry:
  - puerta_abierta=1, counter=T_PUERTA.
  - One cycle of clear_solicitudes for the dir bit of this floor.
  - If nothing remains ahead in dir, clear both bits of the floor and flip dir.
- PUERTA:
  - A new request for this floor in the current dir while the door is open: reload the counter and pulse-clear that bit.
  - Counter reaches 0 -> puerta_abierta=0, go REPOSO.
- Motor and door are never active together: accion[1]=1 implies puerta_abierta=0.
- Boundary cases:
  - Floor 0: bajar bit never steers motion; floor 4: subir bit never steers motion. Both are still cleared on a stop there.
  - solicitudes all zero in MOVIENDO (requests withdrawn externally): stop at the next aligned floor and go PUERTA with no clear pulse.
  - clear_solicitudes is zero in every cycle except the ones specified above.
- Fault handling:
  - piso_actual>4 in any state -> FALLA next cycle: accion=00, puerta_abierta=0, error_piso=1.
  - FALLA exits only by reset.
- Reset asserted mid-trip: outputs return to reset values immediately (asynchronous) and no clear pulses are emitted.

Test Plan:
1. Reset, piso_actual=0, en_piso=1, solicitudes[7]=1 (piso3 subir) -> ARRANQUE 4 cycles, accion=10; floors 1,2 pass without stopping; at floor 3 accion=00, clear_solicitudes=10'h080 for 1 cycle, puerta_abierta=1 for 200 cycles, then FSM_ready=1.
2. At piso 2 going up with solicitudes = piso1 bajar (bit2) and piso4 bajar (bit8) -> continue to floor 4, stop, clear bits 9:8 (pulse 10'h300), dir flips; then travel down and stop at floor 1, clear bit2.
3. Idle at floor 1 with door closed, solicitudes[3]=1 (this floor subir) -> PUERTA next cycle, accion stays 00, pulse 10'h008.
4. In PUERTA going up at floor 2, set bit5 at counter=10 -> counter reloads to 200 and 10'h020 pulses once.
5. piso_actual=3'b110 while MOVIENDO -> next cycle accion=00, error_piso=1; stays set until _reset_n_ goes low.
6. Assert _reset_n_ low while accion=11 -> accion=00 without waiting for a clock edge; after release state=REPOSO and dir=subir.
